// File: rtl/mem_bist_pkg.sv
// Shared types and the test-pattern generator for the memory BIST initiator.
package mem_bist_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] RAM_TOP = 16'h1FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_t;

  // Round 1 inverts round 0 so every cell bit is exercised at both values.
  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] addr,
                                            input logic              round,
                                            input logic [DATA_W-1:0] seed);
    return round ? ~(addr ^ seed) : (addr ^ seed);
  endfunction

endpackage

// File: rtl/mem_bist_rdpipe.sv
// Aligns expected data and address with the Memory read latency (0 or 1 cycle).
module mem_bist_rdpipe
  import mem_bist_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] exp_p0,
  input  logic [DATA_W-1:0] addr_p0,
  output logic              vld_p1,
  output logic [DATA_W-1:0] exp_p1,
  output logic [DATA_W-1:0] addr_p1
);

  generate
    if (RD_LAT == 0) begin : g_comb
      assign vld_p1  = vld_p0;
      assign exp_p1  = exp_p0;
      assign addr_p1 = addr_p0;
    end else begin : g_reg
      // ---- stage p0 -> p1: read data returns one cycle after the address ----
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
        exp_p1  <= exp_p0;
        addr_p1 <= addr_p0;
      end
    end
  endgenerate

endmodule

// File: rtl/mem_bist.sv
// Memory BIST master: write pattern, read back, then repeat with the complement.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADDR_BASE = 16'd0,
  parameter logic [DATA_W-1:0] ADDR_LAST = 16'd1023,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5A5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] address,
  output logic              load,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] err_count,
  output logic [DATA_W-1:0] first_err_addr
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  state_t            state, state_n;
  logic              round, round_n;
  logic [DATA_W-1:0] addr_n, wdata_n, err_n, first_n;
  logic              load_n, busy_n, done_n, pass_n, rnd_end;

  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] exp_p0, exp_p1, addr_p1;

  assign vld_p0 = (state == S_RD);
  assign exp_p0 = pat(address, round, SEED);

  mem_bist_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk    (clk),
    .reset  (reset),
    .vld_p0 (vld_p0),
    .exp_p0 (exp_p0),
    .addr_p0(address),
    .vld_p1 (vld_p1),
    .exp_p1 (exp_p1),
    .addr_p1(addr_p1)
  );

  always_comb begin
    state_n = state;
    round_n = round;
    addr_n  = address;
    load_n  = 1'b0;
    wdata_n = '0;
    busy_n  = busy;
    done_n  = done;
    err_n   = err_count;
    first_n = first_err_addr;
    rnd_end = 1'b0;

    if (vld_p1 && (rdata != exp_p1)) begin
      err_n = sat_inc(err_count);
      if (err_count == '0) first_n = addr_p1;
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_WR;
          round_n = 1'b0;
          addr_n  = ADDR_BASE;
          load_n  = 1'b1;
          wdata_n = pat(ADDR_BASE, 1'b0, SEED);
          busy_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = '0;
          first_n = '0;
        end
      end
      S_WR: begin
        if (address == ADDR_LAST) begin
          state_n = S_RD;
          addr_n  = ADDR_BASE;
        end else begin
          addr_n  = address + 16'd1;
          load_n  = 1'b1;
          wdata_n = pat(address + 16'd1, round, SEED);
        end
      end
      S_RD: begin
        if (address == ADDR_LAST) begin
          if (RD_LAT == 1) state_n = S_DRAIN;
          else             rnd_end = 1'b1;
        end else begin
          addr_n = address + 16'd1;
        end
      end
      S_DRAIN: rnd_end = 1'b1;
      default: state_n = S_IDLE;
    endcase

    if (rnd_end) begin
      if (!round) begin
        state_n = S_WR;
        round_n = 1'b1;
        addr_n  = ADDR_BASE;
        load_n  = 1'b1;
        wdata_n = pat(ADDR_BASE, 1'b1, SEED);
      end else begin
        state_n = S_DONE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end

    // Uses the post-compare count so a DRAIN-cycle miss still clears pass.
    pass_n = done_n && (err_n == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      round          <= 1'b0;
      address        <= '0;
      load           <= 1'b0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      round          <= round_n;
      address        <= addr_n;
      load           <= load_n;
      wdata          <= wdata_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
    end
  end

endmodule
